pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage RV32I core. It decodes the instruction in ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also generates the load-use stall, branch/jump flush, PC-load and EX-stage forwarding selects. It replaces the single-cycle combinational decoder and drives the datapath muxes stage by stage.

---
 rtl/pipe_ctrl_unit.sv | 185 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - RV32I pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazards, forwarding
module pipe_ctrl_unit #(
    parameter int REG_AW         = 5,
    parameter int ALU_CW         = 4,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              func7,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              brnch,
    output logic              stall,
    output logic              flush,
    output logic              pc_load,
    output logic              illegal,
    output logic [ALU_CW-1:0] ex_aluCont,
    output logic              ex_alumux1sel,
    output logic              ex_alumux2sel,
    output logic [2:0]        ex_imm,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_DMwriteEn,
    output logic              mem_DMread,
    output logic              wb_rdEn,
    output logic [1:0]        wb_rdmuxSel,
    output logic [REG_AW-1:0] wb_rd
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [3:0] w_alu;
    logic       w_mux1, w_mux2;
    logic [2:0] w_imm;
    logic       w_rs1r, w_rs2r, w_dmwe, w_dmrd, w_rden, w_br, w_jmp, w_known;
    logic [1:0] w_rdmux;
    logic       w_load_use, w_bubble;

    always_comb begin
        w_alu   = 4'b0000;
        w_mux1  = 1'b0;
        w_mux2  = 1'b0;
        w_imm   = 3'b000;
        w_rs1r  = 1'b0;
        w_rs2r  = 1'b0;
        w_dmwe  = 1'b0;
        w_dmrd  = 1'b0;
        w_rden  = 1'b0;
        w_rdmux = 2'b00;
        w_br    = 1'b0;
        w_jmp   = 1'b0;
        w_known = 1'b1;
        case (opcode)
            OP_R: begin
                w_alu = {func7, func3};
                w_rs1r = 1'b1; w_rs2r = 1'b1; w_rden = 1'b1;
            end
            OP_I: begin
                // Only the shift-right-immediate form carries func7 (srli/srai)
                w_alu = {(func3 == 3'b101) ? func7 : 1'b0, func3};
                w_rs1r = 1'b1; w_rden = 1'b1; w_mux2 = 1'b1;
                w_imm = (func3 == 3'b101) ? 3'b101 : 3'b000;
            end
            OP_LOAD: begin
                w_rs1r = 1'b1; w_dmrd = 1'b1; w_rden = 1'b1;
                w_rdmux = 2'b01; w_mux2 = 1'b1;
            end
            OP_STORE: begin
                w_rs1r = 1'b1; w_rs2r = 1'b1; w_dmwe = 1'b1;
                w_mux2 = 1'b1; w_imm = 3'b001;
            end
            OP_BR: begin
                w_rs1r = 1'b1; w_rs2r = 1'b1; w_mux1 = 1'b1; w_mux2 = 1'b1;
                w_imm = 3'b010; w_br = 1'b1;
            end
            OP_JAL: begin
                w_rden = 1'b1; w_rdmux = 2'b10; w_mux1 = 1'b1; w_mux2 = 1'b1;
                w_imm = 3'b011; w_jmp = 1'b1;
            end
            OP_JALR: begin
                w_rs1r = 1'b1; w_rden = 1'b1; w_rdmux = 2'b10; w_mux2 = 1'b1;
                w_jmp = 1'b1;
            end
            OP_LUI: begin
                w_rden = 1'b1; w_rdmux = 2'b11; w_imm = 3'b100;
            end
            OP_AUIPC: begin
                w_rden = 1'b1; w_mux1 = 1'b1; w_mux2 = 1'b1; w_imm = 3'b100;
            end
            default: w_known = 1'b0;
        endcase
        if (id_rd == '0)
            w_rden = 1'b0;
        if (!id_valid) begin
            w_rs1r = 1'b0; w_rs2r = 1'b0; w_dmwe = 1'b0; w_dmrd = 1'b0;
            w_rden = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
        end
    end

    logic              r_ex_valid, r_ex_mux1, r_ex_mux2, r_ex_dmwe, r_ex_dmrd, r_ex_rden;
    logic              r_ex_br, r_ex_jmp, r_ex_illegal;
    logic [3:0]        r_ex_alu;
    logic [2:0]        r_ex_imm;
    logic [1:0]        r_ex_rdmux;
    logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic              r_mem_valid, r_mem_dmwe, r_mem_dmrd, r_mem_rden;
    logic [1:0]        r_mem_rdmux;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_valid, r_wb_rden;
    logic [1:0]        r_wb_rdmux;
    logic [REG_AW-1:0] r_wb_rd;

    always_comb begin
        pc_load    = r_ex_valid & (r_ex_jmp | (r_ex_br & brnch));
        flush      = pc_load;
        w_load_use = (LOAD_USE_STALL != 0) & id_valid & r_ex_valid & r_ex_dmrd & (r_ex_rd != '0) &
                     ((w_rs1r & (id_rs1 == r_ex_rd)) | (w_rs2r & (id_rs2 == r_ex_rd)));
        stall      = w_load_use & ~flush;
        w_bubble   = flush | stall | ~id_valid | ~w_known;
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_mem_rden && r_mem_rd == r_ex_rs1)     fwd_a = 2'b01;
        else if (r_wb_rden && r_wb_rd == r_ex_rs1)  fwd_a = 2'b10;
        if (r_mem_rden && r_mem_rd == r_ex_rs2)     fwd_b = 2'b01;
        else if (r_wb_rden && r_wb_rd == r_ex_rs2)  fwd_b = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_ex_valid <= 1'b0; r_ex_mux1 <= 1'b0; r_ex_mux2 <= 1'b0;
            r_ex_dmwe  <= 1'b0; r_ex_dmrd <= 1'b0; r_ex_rden <= 1'b0;
            r_ex_br    <= 1'b0; r_ex_jmp  <= 1'b0;
            r_ex_alu   <= '0;   r_ex_imm  <= '0;   r_ex_rdmux <= '0;
            r_ex_rd    <= '0;   r_ex_rs1  <= '0;   r_ex_rs2   <= '0;
            // An unknown opcode still leaves a tagged bubble unless the slot is being killed
            r_ex_illegal <= ~rst & id_valid & ~w_known & ~flush & ~stall;
        end else begin
            r_ex_valid <= 1'b1;      r_ex_mux1 <= w_mux1;  r_ex_mux2 <= w_mux2;
            r_ex_dmwe  <= w_dmwe;    r_ex_dmrd <= w_dmrd;  r_ex_rden <= w_rden;
            r_ex_br    <= w_br;      r_ex_jmp  <= w_jmp;   r_ex_illegal <= 1'b0;
            r_ex_alu   <= w_alu;     r_ex_imm  <= w_imm;   r_ex_rdmux <= w_rdmux;
            r_ex_rd    <= id_rd;     r_ex_rs1  <= id_rs1;  r_ex_rs2   <= id_rs2;
        end

        if (rst) begin
            r_mem_valid <= 1'b0; r_mem_dmwe <= 1'b0; r_mem_dmrd <= 1'b0;
            r_mem_rden  <= 1'b0; r_mem_rdmux <= '0;  r_mem_rd   <= '0;
            r_wb_valid  <= 1'b0; r_wb_rden  <= 1'b0; r_wb_rdmux <= '0;
            r_wb_rd     <= '0;
        end else begin
            r_mem_valid <= r_ex_valid; r_mem_dmwe  <= r_ex_dmwe;  r_mem_dmrd <= r_ex_dmrd;
            r_mem_rden  <= r_ex_rden;  r_mem_rdmux <= r_ex_rdmux; r_mem_rd   <= r_ex_rd;
            r_wb_valid  <= r_mem_valid; r_wb_rden  <= r_mem_rden; r_wb_rdmux <= r_mem_rdmux;
            r_wb_rd     <= r_mem_rd;
        end
    end

    assign illegal       = r_ex_illegal;
    assign ex_aluCont    = ALU_CW'(r_ex_alu);
    assign ex_alumux1sel = r_ex_mux1;
    assign ex_alumux2sel = r_ex_mux2;
    assign ex_imm        = r_ex_imm;
    assign mem_DMwriteEn = r_mem_dmwe;
    assign mem_DMread    = r_mem_dmrd;
    assign wb_rdEn       = r_wb_rden;
    assign wb_rdmuxSel   = r_wb_rdmux;
    assign wb_rd         = r_wb_rd;

    logic w_unused;
    assign w_unused = r_wb_valid;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed vector bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, BAD = 7'b1111111;

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid = 1'b0, func7 = 1'b0, brnch = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic stall, flush, pc_load, illegal, ex_alumux1sel, ex_alumux2sel;
    logic mem_DMwriteEn, mem_DMread, wb_rdEn;
    logic [3:0] ex_aluCont;
    logic [2:0] ex_imm;
    logic [1:0] fwd_a, fwd_b, wb_rdmuxSel;
    logic [4:0] wb_rd;

    logic n_stall, n_flush, n_pc_load, n_illegal, n_mux1, n_mux2, n_dmwe, n_dmrd, n_rden;
    logic [3:0] n_alu;
    logic [2:0] n_imm;
    logic [1:0] n_fa, n_fb, n_rdmux;
    logic [4:0] n_rd;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ALU_CW(4), .LOAD_USE_STALL(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func3(func3), .func7(func7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .brnch(brnch),
        .stall(stall), .flush(flush), .pc_load(pc_load), .illegal(illegal),
        .ex_aluCont(ex_aluCont), .ex_alumux1sel(ex_alumux1sel), .ex_alumux2sel(ex_alumux2sel),
        .ex_imm(ex_imm), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_DMwriteEn(mem_DMwriteEn),
        .mem_DMread(mem_DMread), .wb_rdEn(wb_rdEn), .wb_rdmuxSel(wb_rdmuxSel), .wb_rd(wb_rd));

    pipe_ctrl_unit #(.REG_AW(5), .ALU_CW(4), .LOAD_USE_STALL(0)) dut_nostall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func3(func3), .func7(func7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .brnch(brnch),
        .stall(n_stall), .flush(n_flush), .pc_load(n_pc_load), .illegal(n_illegal),
        .ex_aluCont(n_alu), .ex_alumux1sel(n_mux1), .ex_alumux2sel(n_mux2),
        .ex_imm(n_imm), .fwd_a(n_fa), .fwd_b(n_fb), .mem_DMwriteEn(n_dmwe),
        .mem_DMread(n_dmrd), .wb_rdEn(n_rden), .wb_rdmuxSel(n_rdmux), .wb_rd(n_rd));

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rs1, rs2, rd;
        logic       br;
        logic       st, fl, pc, il;
        logic [3:0] alu;
        logic [1:0] fa, fb;
        logic       dmwe, wben;
        logic [1:0] wbmux;
        logic [4:0] wbrd;
    } vec_t;

    vec_t tbl [23];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic br, input logic st,
                                input logic fl, input logic pc, input logic il,
                                input logic [3:0] alu, input logic [1:0] fa, input logic [1:0] fb,
                                input logic dmwe, input logic wben, input logic [1:0] wbmux,
                                input logic [4:0] wbrd);
        vec_t t;
        t.v = v; t.op = op; t.f3 = f3; t.f7 = f7; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.br = br;
        t.st = st; t.fl = fl; t.pc = pc; t.il = il; t.alu = alu; t.fa = fa; t.fb = fb;
        t.dmwe = dmwe; t.wben = wben; t.wbmux = wbmux; t.wbrd = wbrd;
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic br);
        id_valid = v; opcode = op; func3 = f3; func7 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; brnch = br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                v  op  f3 f7 rs1 rs2 rd br   st fl pc il alu      fa     fb     dw wen wbmux  wbrd
        tbl[0]  = mk(1, R,  0, 0, 1, 2, 3, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[1]  = mk(1, R,  0, 1, 3, 1, 4, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[2]  = mk(1, R,  6, 0, 3, 4, 5, 0,  0, 0, 0, 0, 4'b1000, 2'b01, 2'b00, 0, 0, 2'b00, 0);
        tbl[3]  = mk(1, I,  0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 4'b0110, 2'b10, 2'b01, 0, 1, 2'b00, 3);
        tbl[4]  = mk(1, I,  5, 1, 5, 3, 6, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 1, 2'b00, 4);
        tbl[5]  = mk(1, LD, 2, 0, 6, 0, 7, 0,  0, 0, 0, 0, 4'b1101, 2'b10, 2'b00, 0, 1, 2'b00, 5);
        tbl[6]  = mk(1, R,  0, 0, 7, 0, 8, 0,  1, 0, 0, 0, 4'b0000, 2'b01, 2'b00, 0, 0, 2'b00, 0);
        tbl[7]  = mk(1, R,  0, 0, 7, 0, 8, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 1, 2'b00, 6);
        tbl[8]  = mk(1, ST, 2, 0, 7, 8, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 0, 1, 2'b01, 7);
        tbl[9]  = mk(1, BR, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b01, 0, 0, 2'b00, 0);
        tbl[10] = mk(1, R,  0, 0, 1, 1, 9, 1,  0, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, 2'b00, 8);
        tbl[11] = mk(0, R,  0, 0, 1, 1, 9, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[12] = mk(1, BR, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[13] = mk(1, LD, 2, 0, 1, 0, 5, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[14] = mk(1, R,  0, 0, 5, 0, 6, 0,  1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[15] = mk(1, R,  0, 0, 5, 0, 6, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[16] = mk(1, JAL,0, 0, 5, 6, 1, 0,  0, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 0, 1, 2'b01, 5);
        tbl[17] = mk(1, R,  0, 0, 1, 1, 2, 0,  0, 1, 1, 0, 4'b0000, 2'b00, 2'b01, 0, 0, 2'b00, 0);
        tbl[18] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 1, 2'b00, 6);
        tbl[19] = mk(1, BAD,0, 0, 1, 2, 3, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 1, 2'b10, 1);
        tbl[20] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[21] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        tbl[22] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'b00, 0);

        // two reset edges with random ID inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 1'($urandom));
            next_cycle();
        end
        @(negedge clk);
        check("reset_outputs", -1, 32'({stall, flush, pc_load, illegal, ex_aluCont, ex_alumux1sel,
              ex_alumux2sel, ex_imm, fwd_a, fwd_b, mem_DMwriteEn, mem_DMread, wb_rdEn,
              wb_rdmuxSel, wb_rd}), 32'd0);
        check("reset_nostall_outputs", -1, 32'({n_stall, n_illegal, n_dmwe, n_rden, n_rd}), 32'd0);

        // store right after reset reaches MEM two edges later
        rst = 1'b0;
        drive(1, ST, 3'd2, 0, 5'd1, 5'd2, 5'd0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("store_ex_dmwe", -2, 32'(mem_DMwriteEn), 32'd0);
        check("store_ex_imm", -2, 32'(ex_imm), 32'd1);
        check("store_ex_mux", -2, 32'({ex_alumux1sel, ex_alumux2sel}), 32'd1);
        next_cycle();
        @(negedge clk);
        check("store_mem_dmwe", -2, 32'(mem_DMwriteEn), 32'd1);

        // reset while a store is in EX must keep it from MEM
        drive(1, ST, 3'd2, 0, 5'd1, 5'd2, 5'd0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dmwe_edge1", -3, 32'(mem_DMwriteEn), 32'd0);
        next_cycle();
        @(negedge clk);
        check("midrst_dmwe_edge2", -3, 32'(mem_DMwriteEn), 32'd0);
        next_cycle();

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].br);
            @(negedge clk);
            check("stall",       i, 32'(stall),         32'(tbl[i].st));
            check("flush",       i, 32'(flush),         32'(tbl[i].fl));
            check("pc_load",     i, 32'(pc_load),       32'(tbl[i].pc));
            check("illegal",     i, 32'(illegal),       32'(tbl[i].il));
            check("ex_aluCont",  i, 32'(ex_aluCont),    32'(tbl[i].alu));
            check("fwd_a",       i, 32'(fwd_a),         32'(tbl[i].fa));
            check("fwd_b",       i, 32'(fwd_b),         32'(tbl[i].fb));
            check("mem_DMwriteEn", i, 32'(mem_DMwriteEn), 32'(tbl[i].dmwe));
            check("wb_rdEn",     i, 32'(wb_rdEn),       32'(tbl[i].wben));
            check("wb_rdmuxSel", i, 32'(wb_rdmuxSel),   32'(tbl[i].wbmux));
            check("wb_rd",       i, 32'(wb_rd),         32'(tbl[i].wbrd));
            check("nostall_stall", i, 32'(n_stall),     32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
